// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: x - y, CHUNK bits per cycle, borrow chain kept in a register.
// Optional compare flags are enabled by defining SERIAL_SUBTRACTOR_FLAGS_EN.
module serial_subtractor #(
  parameter int WIDTH  = 32,
  parameter int CHUNK  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_req_valid,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_req_ready,
  output logic             out_rsp_valid,
  input  logic             in_rsp_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_borrow,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_lt,
  output logic             out_ltu
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] res_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] xc;
  logic [CHUNK-1:0] yc;
  logic [CHUNK:0]   sub;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_raw;
  logic             last;

  // One chunk of the ripple per cycle; res_nxt is the result including this chunk.
  always_comb begin
    xc      = '0;
    yc      = '0;
    res_nxt = res_q;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        xc = x_q[i*CHUNK +: CHUNK];
        yc = y_q[i*CHUNK +: CHUNK];
      end
    end
    sub = {1'b0, xc} - {1'b0, yc} - {{CHUNK{1'b0}}, borrow_q};
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) res_nxt[i*CHUNK +: CHUNK] = sub[CHUNK-1:0];
    end
    ovf_raw = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (res_nxt[WIDTH-1] != x_q[WIDTH-1]);
    last    = (cnt == CW'(N - 1));
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state         <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      res_q         <= '0;
      borrow_q      <= 1'b0;
      cnt           <= '0;
      out_req_ready <= 1'b1;
      out_rsp_valid <= 1'b0;
      out_result    <= '0;
      out_borrow    <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_req_valid) begin
            x_q           <= in_x;
            y_q           <= in_y;
            borrow_q      <= 1'b0;
            cnt           <= '0;
            out_req_ready <= 1'b0;
            state         <= RUN;
          end
        end
        RUN: begin
          res_q    <= res_nxt;
          borrow_q <= sub[CHUNK];
          cnt      <= cnt + CW'(1);
          if (last) begin
            // Outputs only change here, so they hold through DONE and IDLE.
            out_result    <= res_nxt;
            out_borrow    <= sub[CHUNK];
            out_overflow  <= SIGNED ? ovf_raw : 1'b0;
            out_rsp_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (in_rsp_ready) begin
            out_rsp_valid <= 1'b0;
            out_req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  // Signed less-than uses the raw overflow so it is correct even when SIGNED=0.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_zero <= 1'b0;
      out_lt   <= 1'b0;
      out_ltu  <= 1'b0;
    end else if (state == RUN && last) begin
      out_zero <= (res_nxt == '0);
      out_lt   <= res_nxt[WIDTH-1] ^ ovf_raw;
      out_ltu  <= sub[CHUNK];
    end
  end
`else
  assign out_zero = 1'b0;
  assign out_lt   = 1'b0;
  assign out_ltu  = 1'b0;
`endif

endmodule
